// File: rtl/fft_spectrum_sink.sv
// AXI4-Stream sink: squares each FFT bin into a RAM of FFT_N/2 magnitudes and tracks the peak bin.
// Latency: frame_valid rises 3 cycles after the final beat; rd_data follows rd_addr by 1 cycle.
// Backpressure: tready is low from the final beat until frame_ack. Optional FFT_SINK_TLAST_CHECK_EN aborts on tlast mismatch.
module fft_spectrum_sink #(
    parameter int FFT_N      = 128,
    parameter int COMP_W     = 24,
    parameter int PEAK_START = 1,
    localparam int ADDR_W    = $clog2(FFT_N),
    localparam int MAG_W     = 2 * COMP_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2*COMP_W-1:0] s_axis_data_tdata,
    input  logic                s_axis_data_tvalid,
    output logic                s_axis_data_tready,
    input  logic                s_axis_data_tlast,
    output logic                frame_valid,
    input  logic                frame_ack,
    output logic [ADDR_W-2:0]   peak_bin,
    output logic [MAG_W-1:0]    peak_mag,
    input  logic [ADDR_W-2:0]   rd_addr,
    output logic [MAG_W-1:0]    rd_data,
    output logic                err_tlast
);

    localparam int                HALF     = FFT_N / 2;
    localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(FFT_N - 1);
    localparam logic [ADDR_W-1:0] PK_LO    = ADDR_W'(PEAK_START);

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic                drain_q, drain_d;
    logic                tready_q, tready_d;
    logic                fvld_q, fvld_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;

    logic                xfer, last_bin, abort, pk_clr, pk_hit;
    logic signed [COMP_W-1:0] re, im;
    logic signed [MAG_W-1:0]  re_x, im_x;

    logic                vld1_q, pk1_q, vld2_q, pk2_q;
    logic [ADDR_W-1:0]   bin1_q, bin2_q;
    logic [MAG_W-1:0]    sq_re_q, sq_im_q, sum_q;
    logic [MAG_W-1:0]    pmag_q;
    logic [ADDR_W-2:0]   pbin_q;
    logic                seen_q;
    logic [MAG_W-1:0]    rd_q;
    logic [MAG_W-1:0]    mem [HALF];

    assign xfer     = s_axis_data_tvalid & tready_q;
    assign last_bin = (cnt_q == LAST_BIN);
    assign re       = s_axis_data_tdata[COMP_W-1:0];
    assign im       = s_axis_data_tdata[2*COMP_W-1:COMP_W];
    assign re_x     = {{COMP_W{re[COMP_W-1]}}, re};
    assign im_x     = {{COMP_W{im[COMP_W-1]}}, im};

`ifdef FFT_SINK_TLAST_CHECK_EN
    logic err_q;
    assign abort = xfer && (s_axis_data_tlast != last_bin);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= abort;
    end
    assign err_tlast = err_q;
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_data_tlast;
    assign abort        = 1'b0;
    assign err_tlast    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        drain_d = 1'b0;
        case (state_q)
            IDLE:    if (xfer && !abort) state_d = CAPTURE;
            CAPTURE: begin
                if (abort)                 state_d = IDLE;
                else if (xfer && last_bin) state_d = DRAIN;
            end
            DRAIN: begin
                // two cycles: stage 2 register, then the RAM write
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = DONE;
                    drain_d = 1'b0;
                end
            end
            DONE:    if (frame_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        tready_d = (state_d == IDLE) || (state_d == CAPTURE);
        fvld_d   = (state_d == DONE);
        cnt_d    = cnt_q;
        if (abort)     cnt_d = '0;
        else if (xfer) cnt_d = cnt_q + 1'b1;
    end

    // Peak restarts on the first beat of a frame; an aborted frame never feeds it again.
    assign pk_clr = (xfer && state_q == IDLE) || abort;
    assign pk_hit = vld2_q && pk2_q && !bin2_q[ADDR_W-1] && (bin2_q >= PK_LO) &&
                    (!seen_q || sum_q > pmag_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            drain_q  <= 1'b0;
            tready_q <= 1'b0;
            fvld_q   <= 1'b0;
            cnt_q    <= '0;
            vld1_q   <= 1'b0;
            pk1_q    <= 1'b0;
            bin1_q   <= '0;
            sq_re_q  <= '0;
            sq_im_q  <= '0;
            vld2_q   <= 1'b0;
            pk2_q    <= 1'b0;
            bin2_q   <= '0;
            sum_q    <= '0;
            pmag_q   <= '0;
            pbin_q   <= '0;
            seen_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            tready_q <= tready_d;
            fvld_q   <= fvld_d;
            cnt_q    <= cnt_d;
            vld1_q   <= xfer;
            pk1_q    <= xfer && !abort;
            bin1_q   <= cnt_q;
            if (xfer) begin
                sq_re_q <= re_x * re_x;
                sq_im_q <= im_x * im_x;
            end
            vld2_q   <= vld1_q;
            pk2_q    <= pk1_q && !abort;
            bin2_q   <= bin1_q;
            if (vld1_q) sum_q <= sq_re_q + sq_im_q;
            if (pk_clr) begin
                pmag_q <= '0;
                pbin_q <= '0;
                seen_q <= 1'b0;
            end else if (pk_hit) begin
                pmag_q <= sum_q;
                pbin_q <= bin2_q[ADDR_W-2:0];
                seen_q <= 1'b1;
            end
        end
    end

    // Upper half of the spectrum mirrors the lower half for real input, so it is dropped.
    always_ff @(posedge clk) begin
        if (vld2_q && !bin2_q[ADDR_W-1]) mem[bin2_q[ADDR_W-2:0]] <= sum_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= '0;
        else        rd_q <= mem[rd_addr];
    end

    assign s_axis_data_tready = tready_q;
    assign frame_valid        = fvld_q;
    assign peak_bin           = pbin_q;
    assign peak_mag           = pmag_q;
    assign rd_data            = rd_q;

endmodule
